// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Pointer width is the address width plus one wrap bit.
package fifo_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clk,
    input  logic              i_WrEn,
    input  logic [ADDR_W-1:0] i_WrAddr,
    input  logic [WIDTH-1:0]  i_WrData,
    input  logic [ADDR_W-1:0] i_RdAddr,
    output logic [WIDTH-1:0]  o_RdData
);

    logic [WIDTH-1:0] r_Mem [DEPTH];

    always_ff @(posedge i_Clk) begin
        if (i_WrEn) begin
            r_Mem[i_WrAddr] <= i_WrData;
        end
    end

    assign o_RdData = r_Mem[i_RdAddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with fill count, almost flags and optional FWFT read.
// Define FIFO_STATS_EN to add the high-water mark and sticky overflow stats.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = MODE_STD,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    localparam int ADDR_W  = clog2(DEPTH),
    localparam int PTR_W   = ptr_w(DEPTH)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_WrEn,
    input  logic [WIDTH-1:0] i_WrData,
    input  logic             i_RdEn,
`ifdef FIFO_STATS_EN
    input  logic             i_ClrStats,
    output logic [ADDR_W:0]  o_MaxCount,
    output logic             o_OvfSticky,
`endif
    output logic [WIDTH-1:0] o_RdData,
    output logic             o_Full,
    output logic             o_Empty,
    output logic             o_AlmostFull,
    output logic             o_AlmostEmpty,
    output logic [ADDR_W:0]  o_Count,
    output logic             o_OverFlow,
    output logic             o_UnderFlow
);

    logic [PTR_W-1:0] r_WrPtr;
    logic [PTR_W-1:0] r_RdPtr;
    logic [PTR_W-1:0] r_Count;
    logic [PTR_W-1:0] w_CountNxt;
    logic             r_OverFlow;
    logic             r_UnderFlow;
    logic             w_Full;
    logic             w_Empty;
    logic             w_WrAcc;
    logic             w_RdAcc;
    logic [WIDTH-1:0] w_MemRd;

    assign w_Full  = (r_Count == PTR_W'(DEPTH));
    assign w_Empty = (r_Count == '0);
    assign w_WrAcc = i_WrEn & ~w_Full;
    assign w_RdAcc = i_RdEn & ~w_Empty;

    always_comb begin
        w_CountNxt = r_Count;
        case ({w_WrAcc, w_RdAcc})
            2'b10:   w_CountNxt = r_Count + PTR_W'(1);
            2'b01:   w_CountNxt = r_Count - PTR_W'(1);
            default: w_CountNxt = r_Count;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_WrPtr     <= '0;
            r_RdPtr     <= '0;
            r_Count     <= '0;
            r_OverFlow  <= 1'b0;
            r_UnderFlow <= 1'b0;
        end else begin
            if (w_WrAcc) r_WrPtr <= r_WrPtr + PTR_W'(1);
            if (w_RdAcc) r_RdPtr <= r_RdPtr + PTR_W'(1);
            r_Count     <= w_CountNxt;
            r_OverFlow  <= i_WrEn & w_Full;
            r_UnderFlow <= i_RdEn & w_Empty;
        end
    end

    fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_Clk    (i_Clk),
        .i_WrEn   (w_WrAcc),
        .i_WrAddr (r_WrPtr[ADDR_W-1:0]),
        .i_WrData (i_WrData),
        .i_RdAddr (r_RdPtr[ADDR_W-1:0]),
        .o_RdData (w_MemRd)
    );

    // FWFT output is forced to zero while empty so reset shows a clean bus
    if (FWFT == MODE_FWFT) begin : g_fwft
        assign o_RdData = w_Empty ? '0 : w_MemRd;
    end else begin : g_std
        logic [WIDTH-1:0] r_RdData;
        always_ff @(posedge i_Clk or negedge i_Rst_n) begin
            if (!i_Rst_n) begin
                r_RdData <= '0;
            end else if (w_RdAcc) begin
                r_RdData <= w_MemRd;
            end
        end
        assign o_RdData = r_RdData;
    end

`ifdef FIFO_STATS_EN
    logic [PTR_W-1:0] r_MaxCount;
    logic             r_OvfSticky;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_MaxCount  <= '0;
            r_OvfSticky <= 1'b0;
        end else if (i_ClrStats) begin
            r_MaxCount  <= r_Count;
            r_OvfSticky <= 1'b0;
        end else begin
            if (w_CountNxt > r_MaxCount) r_MaxCount <= w_CountNxt;
            if (i_WrEn & w_Full) r_OvfSticky <= 1'b1;
        end
    end

    assign o_MaxCount  = r_MaxCount;
    assign o_OvfSticky = r_OvfSticky;
`endif

    assign o_Full        = w_Full;
    assign o_Empty       = w_Empty;
    assign o_AlmostFull  = (r_Count >= PTR_W'(AF_LEVEL));
    assign o_AlmostEmpty = (r_Count <= PTR_W'(AE_LEVEL));
    assign o_Count       = r_Count;
    assign o_OverFlow    = r_OverFlow;
    assign o_UnderFlow   = r_UnderFlow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench: standard and FWFT instances share stimulus, one queue model.
module tb_fifo_sync_param;

    localparam int W = 8;
    localparam int D = 4;
    localparam int AF = D - 1;
    localparam int AE = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr;
    logic [W-1:0] wdata;
    logic         rd;
    logic         clr;

    logic [W-1:0] s_rd, f_rd;
    logic         s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic         f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [2:0]   s_cnt, f_cnt;
`ifdef FIFO_STATS_EN
    logic [2:0]   s_max, f_max;
    logic         s_stk, f_stk;
`endif

    always #5 clk = ~clk;

    fifo_sync_param #(.WIDTH(W), .DEPTH(D), .FWFT(0)) dut_s (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_WrEn(wr), .i_WrData(wdata),
        .i_RdEn(rd),
`ifdef FIFO_STATS_EN
        .i_ClrStats(clr), .o_MaxCount(s_max), .o_OvfSticky(s_stk),
`endif
        .o_RdData(s_rd), .o_Full(s_full), .o_Empty(s_empty),
        .o_AlmostFull(s_af), .o_AlmostEmpty(s_ae), .o_Count(s_cnt),
        .o_OverFlow(s_ovf), .o_UnderFlow(s_unf)
    );

    fifo_sync_param #(.WIDTH(W), .DEPTH(D), .FWFT(1)) dut_f (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_WrEn(wr), .i_WrData(wdata),
        .i_RdEn(rd),
`ifdef FIFO_STATS_EN
        .i_ClrStats(clr), .o_MaxCount(f_max), .o_OvfSticky(f_stk),
`endif
        .o_RdData(f_rd), .o_Full(f_full), .o_Empty(f_empty),
        .o_AlmostFull(f_af), .o_AlmostEmpty(f_ae), .o_Count(f_cnt),
        .o_OverFlow(f_ovf), .o_UnderFlow(f_unf)
    );

    typedef struct {
        int           cnt;
        bit           ovf;
        bit           unf;
        logic [W-1:0] rd;
        bit           fv;
        logic [W-1:0] fd;
        int           maxc;
        bit           stk;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] mq[$];
    logic [W-1:0] last_rd;
    int           maxc;
    bit           stk;
    int           n_chk = 0;
    int           n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one FIFO as a queue; acceptance decided from its occupancy before the edge.
    task automatic step(input bit w, input logic [W-1:0] d, input bit r);
        int   c0;
        bit   full, empty;
        exp_t e;
        wr    = w;
        wdata = d;
        rd    = r;
        @(posedge clk);
        c0    = mq.size();
        full  = (c0 == D);
        empty = (c0 == 0);
        if (r && !empty) last_rd = mq.pop_front();
        if (w && !full) mq.push_back(d);
        if (clr) begin
            maxc = c0;
            stk  = 0;
        end else begin
            if (mq.size() > maxc) maxc = mq.size();
            if (w && full) stk = 1;
        end
        e.cnt  = mq.size();
        e.ovf  = w && full;
        e.unf  = r && empty;
        e.rd   = last_rd;
        e.fv   = (mq.size() != 0);
        e.fd   = e.fv ? mq[0] : '0;
        e.maxc = maxc;
        e.stk  = stk;
        sb.push_back(e);
        #1;
        wr  = 0;
        rd  = 0;
        clr = 0;
    endtask

    exp_t m;
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            m = sb.pop_front();
            chk("s_count", 32'(s_cnt), m.cnt);
            chk("f_count", 32'(f_cnt), m.cnt);
            chk("s_full", 32'(s_full), 32'(m.cnt == D));
            chk("s_empty", 32'(s_empty), 32'(m.cnt == 0));
            chk("f_empty", 32'(f_empty), 32'(m.cnt == 0));
            chk("s_afull", 32'(s_af), 32'(m.cnt >= AF));
            chk("s_aempty", 32'(s_ae), 32'(m.cnt <= AE));
            chk("f_afull", 32'(f_af), 32'(m.cnt >= AF));
            chk("s_ovf", 32'(s_ovf), 32'(m.ovf));
            chk("s_unf", 32'(s_unf), 32'(m.unf));
            chk("f_ovf", 32'(f_ovf), 32'(m.ovf));
            chk("s_rdata", 32'(s_rd), 32'(m.rd));
            if (m.fv) chk("f_rdata", 32'(f_rd), 32'(m.fd));
`ifdef FIFO_STATS_EN
            chk("s_maxcount", 32'(s_max), m.maxc);
            chk("s_ovfsticky", 32'(s_stk), 32'(m.stk));
            chk("f_maxcount", 32'(f_max), m.maxc);
`endif
        end
    end

    task automatic check_reset_state();
        chk("rst_empty", 32'(s_empty), 1);
        chk("rst_count", 32'(s_cnt), 0);
        chk("rst_full", 32'(s_full), 0);
        chk("rst_af", 32'(s_af), 0);
        chk("rst_ae", 32'(s_ae), 1);
        chk("rst_ovf", 32'(s_ovf), 0);
        chk("rst_unf", 32'(s_unf), 0);
        chk("rst_rdata", 32'(s_rd), 0);
        chk("rst_f_rdata", 32'(f_rd), 0);
        chk("rst_f_empty", 32'(f_empty), 1);
`ifdef FIFO_STATS_EN
        chk("rst_maxcount", 32'(s_max), 0);
        chk("rst_sticky", 32'(s_stk), 0);
`endif
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst_n = 0;
        #1;
        check_reset_state();
        mq.delete();
        last_rd = '0;
        maxc    = 0;
        stk     = 0;
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 0;
        wr      = 0;
        rd      = 0;
        clr     = 0;
        wdata   = '0;
        last_rd = '0;
        maxc    = 0;
        stk     = 0;
        #12;
        check_reset_state();
        rst_n = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0);
        step(1, 8'hFF, 0);
        step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        step(1, 8'hE0, 0);
        step(1, 8'hE1, 0);
        step(1, 8'hB5, 1);
        for (int i = 0; i < 10; i++) step(1, 8'h50 + 8'(i), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(1, 8'hC3, 0);
        step(0, 0, 1);
        step(0, 0, 0);

        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        step(1, 8'h33, 0);
        mid_reset();
        step(1, 8'hD1, 0);
        step(0, 0, 1);
        step(1, 8'h01, 0);
        step(1, 8'h02, 0);
        step(1, 8'h03, 0);
        step(0, 0, 1);
        clr = 1;
        step(0, 0, 0);
        step(0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(15) == 0);
            step(($urandom_range(2) != 0), 8'($urandom),
                 ($urandom_range(2) != 0));
        end

        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's basic FIFO.
- Adds a fill-level count, programmable almost-full/almost-empty flags, and a selectable first-word-fall-through (FWFT) read mode.
- Used as the generic buffer between SOC peripherals (UART, SPI, bus bridges) and the CPU-side bus logic.

Parameters:
- WIDTH, 8: data word width in bits, ≥1.
- DEPTH, 16: number of entries; power of two, ≥2. ADDR_W = clog2(DEPTH).
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-1: o_AlmostFull asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 1: o_AlmostEmpty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.

Ports:
- i_Clk  in  1  clock; all state updates on the rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_WrEn  in  1  write request.
- i_WrData  in  WIDTH  write data.
- i_RdEn  in  1  read request (pop in FWFT mode).
- o_RdData  out  WIDTH  read data.
- o_Full  out  1  count == DEPTH.
- o_Empty  out  1  count == 0.
- o_AlmostFull  out  1  count ≥ AF_LEVEL.
- o_AlmostEmpty  out  1  count ≤ AE_LEVEL.
- o_Count  out  ADDR_W+1  current number of stored entries.
- o_OverFlow  out  1  one-cycle pulse: write rejected.
- o_UnderFlow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Clocking and reset: one clock, i_Clk. Reset is asynchronous and active-low on i_Rst_n.
- Values while i_Rst_n is low:
  - pointers = 0, count = 0, o_RdData = 0.
  - o_Empty = 1, o_Full = 0, o_AlmostEmpty = 1, o_AlmostFull = 0 (AF_LEVEL ≥ 1).
  - o_OverFlow = 0, o_UnderFlow = 0.
  - Memory contents are not cleared.
- Reset mid-operation discards all entries immediately. The first accepted write after release is the head.
- Pointers are ADDR_W+1 bits (extra wrap bit) and wrap naturally modulo 2·DEPTH. Storage address = low ADDR_W bits.
- Write accept = i_WrEn & ~o_Full. An accepted write stores i_WrData at the write pointer and increments it.
- Write while full is never accepted, even with a simultaneous accepted read. o_OverFlow pulses for the next cycle; state is unchanged.
- Read accept = i_RdEn & ~o_Empty; the read pointer increments. Read while empty pulses o_UnderFlow; state is unchanged.
- Simultaneous write and read:
  - Both accepted: count unchanged; both pointers advance.
  - Empty case: the read underflows, the write is accepted, and count becomes 1.
- Count: +1 on write-only accept, −1 on read-only accept, otherwise held. All flags are decoded from the registered count, so they change in the cycle after the causing edge.
- FWFT=0 (standard read):
  - An accepted read registers mem[rd_ptr] into o_RdData. Data is visible one cycle after the i_RdEn edge.
  - o_RdData holds its value when no read is accepted.
- FWFT=1 (first-word-fall-through):
  - o_RdData = mem[rd_ptr] whenever o_Empty = 0, i.e. zero read latency.
  - The first written word appears the cycle after its write edge.
  - i_RdEn acts as pop/acknowledge.
  - o_RdData is don't-care while empty; the bench must not check it then.
- Overflow/underflow pulses are registered and last exactly one cycle per offending request.

Optional Feature:
- Macro: FIFO_STATS_EN.
- Defined:
  - Adds port i_ClrStats (in, 1) and port o_MaxCount (out, ADDR_W+1).
  - o_MaxCount holds the high-water mark of count since reset or clear; reset value 0.
  - i_ClrStats loads o_MaxCount with the current count on the next edge; the clear has priority over the update.
  - Adds o_OvfSticky (out, 1): set by any overflow, cleared by i_ClrStats.
- Undefined: these ports and their logic do not exist; the rest of the block is unchanged.

Decomposition:
- Shared package fifo_pkg holds:
  - clog2 function;
  - constant MODE_STD = 0 and constant MODE_FWFT = 1;
  - a localparam recipe for pointer width.
- Sub-module fifo_mem: simple dual-port array with a synchronous write port and an asynchronous read port. The top level adds the output register in standard mode.
- Pointer, count and flag logic stay in the top level.

Test Plan:
- Default build, WIDTH=8 DEPTH=4 FWFT=0. Write 0xA0–0xA3 on consecutive cycles. Expected:
  - o_Count steps 1→4; o_Full = 1 after the 4th edge.
  - o_AlmostFull (AF=3) rises after the 3rd edge.
  - Four reads then return 0xA0, 0xA1, 0xA2, 0xA3, each one cycle after its i_RdEn edge; o_Empty = 1 at the end.
- Full, then write 0xFF → o_OverFlow high for exactly 1 cycle; o_Count stays 4; a later read sequence returns no 0xFF.
- Empty, then i_RdEn for 2 cycles → o_UnderFlow high for 2 cycles; o_Count stays 0; o_RdData unchanged.
- Count 2, simultaneous write 0xB5 and read:
  - Returns the old head; o_Count stays 2.
  - Wrap test: 10 write/read pairs return data in order across pointer wrap.
- FWFT=1, write 0xC3 → o_RdData = 0xC3 and o_Empty = 0 one cycle after the write edge. Pop with i_RdEn → o_Empty = 1 the next cycle.
- Load 3 entries, pulse i_Rst_n low mid-cycle. Expected:
  - Immediately: o_Empty = 1, o_Count = 0, o_RdData = 0.
  - After release, write 0xD1 then read → 0xD1.
  - With FIFO_STATS_EN: o_MaxCount = 0 after reset, 3 after refilling, and equal to the current count after i_ClrStats.
